scan_seq3: RTL and testbench

Upstream stage for the 3-to-8 decoder. Steps a 3-bit channel index through the enabled channels of an 8-bit mask, holding each channel for a programmable dwell time, and drives the decoder select inputs `x`, `y`, `z` plus a qualifying `active` strobe. The decoder has no enable input, so downstream logic gates its one-hot output with `active`. Typical uses are LED/display multiplexing and round-robin polling of eight peripherals.

---
 rtl/scan_seq3_pkg.sv | 23 ++
 rtl/scan_seq3_if.sv | 25 ++
 rtl/scan_seq3_rr_next_idx.sv | 32 +++
 rtl/scan_seq3.sv | 87 ++++++++
 tb/tb_scan_seq3.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/scan_seq3_pkg.sv
// Shared types and helpers for the channel scanner and its round-robin search.
// Combinational helpers only; no state.
package scan_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Lowest enabled channel; returns 0 for an empty mask (callers gate on that).
    function automatic logic [SELW-1:0] lowest_set(input logic [NCH-1:0] m);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) r = SELW'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_seq3_if.sv
// Control and select bundle between the scanner and its user.
// master drives requests and mask; slave (the scanner) drives select and strobes.
interface scan_seq3_if;
    import scan_pkg::*;

    logic            start;
    logic            stop;
    logic [NCH-1:0]  mask;
    logic            x;
    logic            y;
    logic            z;
    logic            active;
    logic            wrap;
    logic            done;

    modport master (
        output start, stop, mask,
        input  x, y, z, active, wrap, done
    );

    modport slave (
        input  start, stop, mask,
        output x, y, z, active, wrap, done
    );
endinterface

// File: rtl/scan_seq3_rr_next_idx.sv
// Circular priority search: next enabled channel strictly above cur, cur itself last.
// Purely combinational; wrapped flags a result at or below cur.
module rr_next_idx
    import scan_pkg::*;
(
    input  logic [NCH-1:0]  mask,
    input  logic [SELW-1:0] cur,
    output logic [SELW-1:0] nxt,
    output logic            wrapped,
    output logic            none
);

    logic [SELW-1:0] cand;
    logic            found;

    always_comb begin
        nxt   = cur;
        cand  = cur;
        found = 1'b0;
        // Offset NCH lands back on cur thanks to the 3-bit modulo add.
        for (int k = 1; k <= NCH; k++) begin
            cand = cur + SELW'(k);
            if (!found && mask[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
        none    = ~|mask;
        wrapped = !none && (nxt <= cur);
    end

endmodule

// File: rtl/scan_seq3.sv
// Steps a 3-bit select through enabled mask channels, DWELL cycles each.
// Select valid one cycle after start; wrap/done decode the current state combinationally.
module scan_seq3
    import scan_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter bit ONESHOT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    scan_seq3_if.slave bus
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    state_t          state_q, state_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;

    logic [SELW-1:0] nxt;
    logic            wrapped;
    logic            none;
    logic            at_adv;

    rr_next_idx u_next (
        .mask    (bus.mask),
        .cur     (idx_q),
        .nxt     (nxt),
        .wrapped (wrapped),
        .none    (none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Advance point; a concurrent stop pre-empts it, so no wrap/done then.
    assign at_adv = (state_q == SCAN) && (dcnt_q == DLAST) && !bus.stop;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && (|bus.mask)) begin
                    state_d = SCAN;
                    idx_d   = lowest_set(bus.mask);
                    dcnt_d  = '0;
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q != DLAST) begin
                    dcnt_d = dcnt_q + 1'b1;
                end else begin
                    dcnt_d = '0;
                    if (none || (ONESHOT && wrapped)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.active = (state_q == SCAN);
    assign bus.x      = bus.active & idx_q[2];
    assign bus.y      = bus.active & idx_q[1];
    assign bus.z      = bus.active & idx_q[0];
    assign bus.wrap   = at_adv && wrapped;
    assign bus.done   = at_adv && (none || (ONESHOT && wrapped));

endmodule

// File: tb/tb_scan_seq3.sv
// Two scanner instances (continuous DWELL=2, one-shot DWELL=3) under shared stimulus,
// scoreboarded against a behavioural channel-walk model.
module tb_scan_seq3;
    import scan_pkg::*;

    localparam int D0 = 2;
    localparam bit O0 = 1'b0;
    localparam int D1 = 3;
    localparam bit O1 = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scan_seq3_if if0 ();
    scan_seq3_if if1 ();

    scan_seq3 #(.DWELL(D0), .ONESHOT(O0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    scan_seq3 #(.DWELL(D1), .ONESHOT(O1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic       start_s = 1'b0;
    logic       stop_s  = 1'b0;
    logic [7:0] mask_s  = 8'h00;

    assign if0.start = start_s;
    assign if0.stop  = stop_s;
    assign if0.mask  = mask_s;
    assign if1.start = start_s;
    assign if1.stop  = stop_s;
    assign if1.mask  = mask_s;

    // Model: is the instance scanning, which channel, how many cycles spent on it.
    bit busy [2];
    int ch   [2];
    int cnt  [2];

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic int dwell_of(int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic bit oneshot_of(int i);
        return (i == 0) ? O0 : O1;
    endfunction

    function automatic int next_ch(logic [7:0] m, int c);
        for (int k = 1; k <= 8; k++) begin
            if (m[(c + k) % 8]) return (c + k) % 8;
        end
        return -1;
    endfunction

    function automatic int low_ch(logic [7:0] m);
        for (int k = 0; k < 8; k++) if (m[k]) return k;
        return -1;
    endfunction

    // Expected {sel[2:0], active, wrap, done} for this cycle's inputs.
    function automatic logic [5:0] expect_out(int i);
        logic [2:0] sel;
        logic       w, d;
        int         n;
        sel = 3'd0; w = 1'b0; d = 1'b0;
        if (busy[i]) begin
            sel = 3'(ch[i]);
            if (cnt[i] == dwell_of(i) - 1 && !stop_s) begin
                n = next_ch(mask_s, ch[i]);
                if (n < 0) d = 1'b1;
                else if (n <= ch[i]) begin
                    w = 1'b1;
                    d = oneshot_of(i);
                end
            end
        end
        return {sel, busy[i], w, d};
    endfunction

    task automatic model_edge(int i);
        int n;
        if (rst) begin
            busy[i] = 0; ch[i] = 0; cnt[i] = 0;
        end else if (!busy[i]) begin
            if (start_s && !stop_s && mask_s != 0) begin
                busy[i] = 1; ch[i] = low_ch(mask_s); cnt[i] = 0;
            end
        end else if (stop_s) begin
            busy[i] = 0; cnt[i] = 0;
        end else if (cnt[i] < dwell_of(i) - 1) begin
            cnt[i]++;
        end else begin
            cnt[i] = 0;
            n = next_ch(mask_s, ch[i]);
            if (n < 0) busy[i] = 0;
            else if (n <= ch[i] && oneshot_of(i)) busy[i] = 0;
            else ch[i] = n;
        end
    endtask

    task automatic step(input logic s, input logic sp, input logic r, input logic [7:0] m);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        start_s = s;
        stop_s  = sp;
        rst     = r;
        mask_s  = m;
        q0.push_back(expect_out(0));
        q1.push_back(expect_out(1));
    endtask

    task automatic idle_run(input int n, input logic [7:0] m);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, m);
    endtask

    // Monitor: compares every presented output against the oldest expectation.
    always @(negedge clk) begin
        logic [5:0] e, a0, a1;
        cyc++;
        a0 = {if0.x, if0.y, if0.z, if0.active, if0.wrap, if0.done};
        a1 = {if1.x, if1.y, if1.z, if1.active, if1.wrap, if1.done};
        if (q0.size() > 0) begin
            e = q0.pop_front();
            checks++;
            if (a0 !== e) begin
                errors++;
                $display("FAIL dut0_outs cyc=%0d got xyz/act/wrap/done=%b exp=%b", cyc, a0, e);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if (a1 !== e) begin
                errors++;
                $display("FAIL dut1_outs cyc=%0d got xyz/act/wrap/done=%b exp=%b", cyc, a1, e);
            end
        end
    end

    initial begin
        logic [7:0] m;
        int         r;
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; ch[i] = 0; cnt[i] = 0;
        end

        // Reset, then continuous full-mask scan long enough for dut1 to finish its pass.
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        idle_run(40, 8'hFF);

        // Stop mid-scan, then start+stop together while idle.
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        idle_run(11, 8'hFF);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        idle_run(2, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        idle_run(3, 8'hFF);

        // Sparse mask.
        step(1'b1, 1'b0, 1'b0, 8'b1010_0100);
        idle_run(20, 8'b1010_0100);
        step(1'b0, 1'b1, 1'b0, 8'b1010_0100);

        // Mask change mid-dwell, on channel 3.
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        idle_run(7, 8'hFF);
        idle_run(12, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h01);

        // Mask cleared during scan, then start with empty mask.
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        idle_run(2, 8'hFF);
        idle_run(6, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        idle_run(3, 8'h00);

        // Single channel.
        step(1'b1, 1'b0, 1'b0, 8'h10);
        idle_run(10, 8'h10);
        step(1'b0, 1'b1, 1'b0, 8'h10);

        // Reset mid-scan.
        step(1'b1, 1'b0, 1'b0, 8'hFF);
        idle_run(5, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 8'hFF);
        idle_run(3, 8'hFF);

        // Randomised traffic.
        m = 8'hFF;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 7);
                if (r == 0) m = 8'h00;
                else if (r == 1) m = 8'(1 << $urandom_range(0, 7));
                else m = 8'($urandom);
            end
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 149) == 0),
                 m);
        end

        @(negedge clk);
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d/%0d required=0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
